// File: rtl/alu_pkg.sv
// Shared types for the digit-serial ALU: op encodings, FSM states and the subtract-path helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SLTU = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Compares reuse the subtractor, so they need the inverted B and the seeded carry too.
  function automatic logic is_sub(input alu_op_e op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU unit; zero latency, no flow control (driven by the serial top).
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [SLICE-1:0] y_s,
  output logic             cout_s,
  output logic             cmsb_s
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum;

  assign b_eff  = is_sub(op) ? ~b_s : b_s;
  assign sum    = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
  // Carry into the MSB, recovered from the sum bit; XOR with cout gives signed overflow.
  assign cmsb_s = sum[SLICE-1] ^ a_s[SLICE-1] ^ b_eff[SLICE-1];

  always_comb begin
    y_s    = '0;
    cout_s = 1'b0;
    case (op)
      OP_AND: y_s = a_s & b_s;
      OP_OR:  y_s = a_s | b_s;
      OP_XOR: y_s = a_s ^ b_s;
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU: begin
        y_s    = sum[SLICE-1:0];
        cout_s = sum[SLICE];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_digit_serial.sv
// Digit-serial ALU, SLICE bits/clock LSB first; out_valid NSLICE edges after the accept edge, result held until out_ready.
// One op in flight, in_ready only in IDLE; status flags zero/neg/ovf exist only when ALU_FLAGS_EN is defined.
module alu_digit_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("alu_digit_serial: WIDTH must be a multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, y_q, y_d;
  alu_op_e          op_q;
  logic             cout_q;
  logic             last_slice;
  logic [SLICE-1:0] y_s;
  logic             cout_s, cmsb_s, arith_ovf;

  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last_slice) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a_s    (a_q[cnt_q*SLICE +: SLICE]),
    .b_s    (b_q[cnt_q*SLICE +: SLICE]),
    .cin    (carry_q),
    .op     (op_q),
    .y_s    (y_s),
    .cout_s (cout_s),
    .cmsb_s (cmsb_s)
  );

  // Compares replace the whole word with the 0/1 verdict once the final slice is known.
  always_comb begin
    arith_ovf                  = cout_s ^ cmsb_s;
    y_d                        = y_q;
    y_d[cnt_q*SLICE +: SLICE]  = y_s;
    if (last_slice && op_q == OP_SLT)
      y_d = {{(WIDTH-1){1'b0}}, y_s[SLICE-1] ^ arith_ovf};
    else if (last_slice && op_q == OP_SLTU)
      y_d = {{(WIDTH-1){1'b0}}, ~cout_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= alu_op_e'(op);
      cnt_q   <= '0;
      carry_q <= is_sub(alu_op_e'(op));
    end else if (state_q == RUN) begin
      y_q     <= y_d;
      carry_q <= cout_s;
      if (last_slice)
        cout_q <= (op_q == OP_ADD || op_q == OP_SUB) ? cout_s : 1'b0;
      else
        cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign y    = y_q;
  assign cout = cout_q;

`ifdef ALU_FLAGS_EN
  logic zero_q, neg_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == RUN && last_slice) begin
      zero_q <= (y_d == '0);
      neg_q  <= y_d[WIDTH-1];
      ovf_q  <= (op_q == OP_ADD || op_q == OP_SUB) && arith_ovf;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`endif

endmodule
